// File: rtl/fsm_pkg.sv
// Shared FSM definitions for the serializer and the downstream 1010 detector's debug ports.
package fsm_pkg;

    // State width; the detector's cs/ns debug ports use it as well.
    localparam int unsigned ST_W = 2;

    // Encodings 2'd2 and 2'd3 are illegal and recover to S_IDLE.
    typedef enum logic [ST_W-1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1
    } state_e;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words over valid/ready and shifts them out one
// bit per clock on a registered serial line. Back-to-back words stream with no gap bit.
module bit_serializer
    import fsm_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             out,
    output logic             busy,
    output logic [ST_W-1:0]  cs,
    output logic [ST_W-1:0]  ns
);

    localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             out_q, out_d;

    logic             last_bit;
    logic             accept;
    logic             din_first;
    logic [WIDTH-1:0] din_adv;
    logic             sr_next;
    logic [WIDTH-1:0] sr_adv;

    // The final bit of the current word is on the line during this cycle.
    assign last_bit  = (state_q == S_SHIFT) && (cnt_q == LastCnt);
    // Ready in the last-bit cycle too, so the next word follows without a gap bit.
    assign din_ready = !rst && ((state_q == S_IDLE) || last_bit);
    assign accept    = din_valid && din_ready;

    // First bit of an incoming word, and the word with that bit consumed.
    assign din_first = MSB_FIRST ? din[WIDTH-1] : din[0];
    assign din_adv   = MSB_FIRST ? {din[WIDTH-2:0], 1'b0} : {1'b0, din[WIDTH-1:1]};
    // Next bit of the word in flight, and the register with that bit consumed.
    assign sr_next   = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
    assign sr_adv    = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};

    // Next-state logic; illegal encodings fall back to idle.
    always_comb begin
        state_d = state_q;
        if (rst) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (accept) state_d = S_SHIFT;
                S_SHIFT: if (last_bit && !accept) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath next values: load on accept, advance mid-word, otherwise park at the idle level.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        out_d = out_q;
        if (accept) begin
            sr_d  = din_adv;
            out_d = din_first;
            cnt_d = '0;
        end else if ((state_q == S_SHIFT) && !last_bit) begin
            sr_d  = sr_adv;
            out_d = sr_next;
            cnt_d = cnt_q + CntW'(1);
        end else begin
            out_d = IDLE_BIT;
            cnt_d = '0;
        end
    end

    // Shift register, bit counter and serial output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
            out_q <= IDLE_BIT;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign out  = out_q;
    assign busy = (state_q == S_SHIFT);
    assign cs   = state_q;
    assign ns   = state_d;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench: two serializer instances (MSB-first/idle 0 and LSB-first/idle 1) share
// stimulus and are compared each cycle against a bit-queue reference model.
module tb_bit_serializer;
    import fsm_pkg::*;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         din_valid;
    logic [W-1:0] din;

    logic         rdy_m, out_m, busy_m;
    logic [1:0]   cs_m, ns_m;
    logic         rdy_l, out_l, busy_l;
    logic [1:0]   cs_l, ns_l;

    int unsigned  n_cmp = 0;
    int unsigned  n_err = 0;

    // Reference model: bits still to be presented, in line order.
    bit           q_m[$];
    bit           q_l[$];

    logic         acc;
    logic         obs_m, obs_l, obs_busy;
    logic [7:0]   words [2];

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_m),
        .out(out_m), .busy(busy_m), .cs(cs_m), .ns(ns_m)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_l (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_l),
        .out(out_l), .busy(busy_l), .cs(cs_l), .ns(ns_l)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, check combinational outputs, advance the model, check registered outputs.
    task automatic cycle(input logic r, input logic v, input logic [W-1:0] d, output logic a);
        logic       exp_rdy;
        logic [1:0] exp_ns;
        logic       exp_busy;
        logic       exp_om, exp_ol;
        @(negedge clk);
        rst = r;
        din_valid = v;
        din = d;
        #1;
        exp_rdy = !r && (q_m.size() == 0);
        a = v && exp_rdy;
        exp_ns = (!r && (a || q_m.size() > 0)) ? 2'd1 : 2'd0;
        check_eq("ready_m", 32'(rdy_m), 32'(exp_rdy));
        check_eq("ready_l", 32'(rdy_l), 32'(exp_rdy));
        check_eq("ns_m", 32'(ns_m), 32'(exp_ns));
        check_eq("ns_l", 32'(ns_l), 32'(exp_ns));
        @(posedge clk);
        if (r) begin
            q_m.delete();
            q_l.delete();
        end else if (a) begin
            for (int i = 0; i < int'(W); i++) begin
                q_m.push_back(d[W-1-i]);
                q_l.push_back(d[i]);
            end
        end
        exp_busy = (q_m.size() > 0);
        exp_om = 1'b0;
        exp_ol = 1'b1;
        if (exp_busy) begin
            exp_om = q_m.pop_front();
            exp_ol = q_l.pop_front();
        end
        #1;
        check_eq("out_m", 32'(out_m), 32'(exp_om));
        check_eq("out_l", 32'(out_l), 32'(exp_ol));
        check_eq("busy_m", 32'(busy_m), 32'(exp_busy));
        check_eq("busy_l", 32'(busy_l), 32'(exp_busy));
        check_eq("cs_m", 32'(cs_m), exp_busy ? 32'd1 : 32'd0);
        check_eq("cs_l", 32'(cs_l), exp_busy ? 32'd1 : 32'd0);
        obs_m = out_m;
        obs_l = out_l;
        obs_busy = busy_m;
    endtask

    initial begin
        logic [7:0]  bits_m, bits_l;
        logic [15:0] stream;
        logic [3:0]  hist;
        int          busy_cnt, idx, nbits, first_acc, second_acc, nhits, hit0, hit1;

        rst = 1'b1;
        din_valid = 1'b0;
        din = '0;
        words[0] = 8'hAA;
        words[1] = 8'hF0;

        // Reset held for two clocks, then idle.
        cycle(1'b1, 1'b0, 8'h00, acc);
        cycle(1'b1, 1'b0, 8'h00, acc);
        check_eq("rst_out_m", 32'(obs_m), 32'd0);
        check_eq("rst_cs_m", 32'(cs_m), 32'd0);
        cycle(1'b0, 1'b0, 8'h00, acc);
        cycle(1'b0, 1'b0, 8'h00, acc);

        // Single word 0xC1 on both bit orders.
        cycle(1'b0, 1'b1, 8'hC1, acc);
        check_eq("c1_accept", 32'(acc), 32'd1);
        bits_m = {7'd0, obs_m};
        bits_l = {7'd0, obs_l};
        busy_cnt = obs_busy ? 1 : 0;
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, 1'b0, 8'h00, acc);
            bits_m = {bits_m[6:0], obs_m};
            bits_l = {bits_l[6:0], obs_l};
            busy_cnt += obs_busy ? 1 : 0;
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 8'h00, acc);
            busy_cnt += obs_busy ? 1 : 0;
        end
        check_eq("c1_msb_bits", 32'(bits_m), 32'h000000C1);
        check_eq("c1_lsb_bits", 32'(bits_l), 32'h00000083);
        check_eq("c1_busy_len", 32'(busy_cnt), 32'd8);
        check_eq("c1_idle_l", 32'(obs_l), 32'd1);

        // Back-to-back 0xAA then 0xF0 with valid held high.
        idx = 0;
        nbits = 0;
        stream = '0;
        first_acc = -1;
        second_acc = -1;
        for (int c = 0; c < 24; c++) begin
            cycle(1'b0, idx < 2, (idx < 2) ? words[idx] : 8'h00, acc);
            if (acc) begin
                if (idx == 0) first_acc = c;
                else second_acc = c;
                idx++;
            end
            if (first_acc >= 0 && nbits < 16) begin
                stream = {stream[14:0], obs_m};
                nbits++;
            end
        end
        check_eq("b2b_stream", 32'(stream), 32'h0000AAF0);
        check_eq("b2b_nbits", 32'(nbits), 32'd16);
        check_eq("b2b_gap", 32'(second_acc - first_acc), 32'd8);

        // Reset on the fourth shift edge of 0xFF, then a clean 0x0F.
        cycle(1'b0, 1'b1, 8'hFF, acc);
        check_eq("ff_accept", 32'(acc), 32'd1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, acc);
        cycle(1'b1, 1'b1, 8'h5A, acc);
        check_eq("midrst_acc", 32'(acc), 32'd0);
        check_eq("midrst_out", 32'(obs_m), 32'd0);
        check_eq("midrst_cs", 32'(cs_m), 32'd0);
        cycle(1'b0, 1'b0, 8'h00, acc);
        cycle(1'b0, 1'b1, 8'h0F, acc);
        bits_m = {7'd0, obs_m};
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, 1'b0, 8'h00, acc);
            bits_m = {bits_m[6:0], obs_m};
        end
        check_eq("after_rst_0f", 32'(bits_m), 32'h0000000F);
        cycle(1'b0, 1'b0, 8'h00, acc);

        // Serial line into a non-overlapping 1010 detector: 0xAA then idle.
        hist = '0;
        nhits = 0;
        hit0 = -1;
        hit1 = -1;
        cycle(1'b0, 1'b1, 8'hAA, acc);
        for (int k = 1; k <= 12; k++) begin
            hist = {hist[2:0], obs_m};
            if (hist == 4'b1010) begin
                if (nhits == 0) hit0 = k;
                else if (nhits == 1) hit1 = k;
                nhits++;
                hist = '0;
            end
            cycle(1'b0, 1'b0, 8'h00, acc);
        end
        check_eq("det_hits", 32'(nhits), 32'd2);
        check_eq("det_first", 32'(hit0), 32'd4);
        check_eq("det_second", 32'(hit1), 32'd8);

        // Random traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 6), 8'($urandom), acc);
        end
        for (int c = 0; c < 10; c++) cycle(1'b0, 1'b0, 8'h00, acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
